// File: rtl/fpnew_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fpnew_issue_pkg
// Purpose : Shared types for the fpnew issue controller. This includes the
//           fpnew-compatible request and status encodings, the ROB entry
//           type and the controller state.
// Revision: 1.0 - initial release
// ============================================================================
package fpnew_issue_pkg;

  localparam int unsigned ROB_FLEN     = 64;
  localparam int unsigned ROB_ID_WIDTH = 8;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef enum logic [2:0] {
    FP32, FP64, FP16, FP8, FP16ALT
  } fp_format_e;

  typedef enum logic [1:0] {
    INT8, INT16, INT32, INT64
  } int_format_e;

  typedef enum logic [2:0] {
    RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011,
    RMM = 3'b100, DYN = 3'b111
  } roundmode_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  typedef struct packed {
    logic                    alloc;
    logic                    done;
    logic [ROB_ID_WIDTH-1:0] id;
    logic [ROB_FLEN-1:0]     result;
    status_t                 status;
  } rob_entry_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam int_format_e INT_FMT_DEFAULT = INT32;

endpackage
`default_nettype wire

// File: rtl/fpnew_issue_rob.sv
`default_nettype none
// ============================================================================
// Module  : fpnew_issue_rob
// Purpose : Reorder buffer holding one slot per FPU tag. It tracks the alloc
//           and done state of each slot and exposes the in-order head entry.
// Revision: 1.0 - initial release
// ============================================================================
module fpnew_issue_rob
  import fpnew_issue_pkg::*;
#(
  parameter int unsigned TAG_WIDTH = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    i_clear,
  input  logic                    i_alloc,
  input  logic [ROB_ID_WIDTH-1:0] i_alloc_id,
  output logic                    o_alloc_busy,
  output logic [TAG_WIDTH-1:0]    o_alloc_ptr,
  input  logic                    i_wr,
  input  logic [TAG_WIDTH-1:0]    i_wr_tag,
  input  logic [ROB_FLEN-1:0]     i_wr_result,
  input  status_t                 i_wr_status,
  output logic                    o_wr_ok,
  input  logic                    i_retire,
  output rob_entry_t              o_head,
  output logic [TAG_WIDTH:0]      o_count
);

  localparam int unsigned DEPTH = 1 << TAG_WIDTH;

  logic [DEPTH-1:0]        r_alloc;
  logic [DEPTH-1:0]        r_done;
  logic [ROB_ID_WIDTH-1:0] r_id     [DEPTH];
  logic [ROB_FLEN-1:0]     r_result [DEPTH];
  status_t                 r_status [DEPTH];
  logic [TAG_WIDTH-1:0]    r_alloc_ptr;
  logic [TAG_WIDTH-1:0]    r_head_ptr;
  logic [TAG_WIDTH:0]      r_count;
  logic                    w_wr_en;

  // A zero-latency FPU may return the tag being allocated in this very cycle.
  assign o_wr_ok = (r_alloc[i_wr_tag] & ~r_done[i_wr_tag])
                 | (i_alloc & (i_wr_tag == r_alloc_ptr));
  assign w_wr_en = i_wr & o_wr_ok;

  assign o_alloc_busy = r_alloc[r_alloc_ptr];
  assign o_alloc_ptr  = r_alloc_ptr;
  assign o_count      = r_count;

  always_comb begin
    o_head        = '0;
    o_head.alloc  = r_alloc[r_head_ptr];
    o_head.done   = r_done[r_head_ptr];
    o_head.id     = r_id[r_head_ptr];
    o_head.result = r_result[r_head_ptr];
    o_head.status = r_status[r_head_ptr];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_alloc     <= '0;
      r_done      <= '0;
      r_alloc_ptr <= '0;
      r_head_ptr  <= '0;
      r_count     <= '0;
    end else if (i_clear) begin
      r_alloc     <= '0;
      r_done      <= '0;
      r_alloc_ptr <= '0;
      r_head_ptr  <= '0;
      r_count     <= '0;
    end else begin
      if (i_alloc) begin
        r_alloc[r_alloc_ptr] <= 1'b1;
        r_alloc_ptr          <= r_alloc_ptr + TAG_WIDTH'(1);
      end
      if (w_wr_en) begin
        r_done[i_wr_tag] <= 1'b1;
      end
      // The head is already done, so it never collides with a result write.
      if (i_retire) begin
        r_alloc[r_head_ptr] <= 1'b0;
        r_done[r_head_ptr]  <= 1'b0;
        r_head_ptr          <= r_head_ptr + TAG_WIDTH'(1);
      end
      if (i_alloc && !i_retire) begin
        r_count <= r_count + (TAG_WIDTH+1)'(1);
      end else if (!i_alloc && i_retire) begin
        r_count <= r_count - (TAG_WIDTH+1)'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (i_alloc) begin
      r_id[r_alloc_ptr] <= i_alloc_id;
    end
    if (w_wr_en) begin
      r_result[i_wr_tag] <= i_wr_result;
      r_status[i_wr_tag] <= i_wr_status;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpnew_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fpnew_issue_ctrl
// Purpose : Issues core commands to an fpnew FPU with issue-order tags. It
//           reorders the tagged results and returns them to the core in order.
// Revision: 1.0 - initial release
// ============================================================================
module fpnew_issue_ctrl
  import fpnew_issue_pkg::*;
#(
  parameter int unsigned FLEN      = ROB_FLEN,
  parameter int unsigned TAG_WIDTH = 2,
  parameter int unsigned ID_WIDTH  = ROB_ID_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [2:0][FLEN-1:0]      cmd_operands_i,
  input  operation_e                cmd_op_i,
  input  logic                      cmd_op_mod_i,
  input  fp_format_e                cmd_fmt_i,
  input  roundmode_e                cmd_rnd_mode_i,
  input  logic                      cmd_vec_i,
  input  logic [ID_WIDTH-1:0]       cmd_id_i,
  output logic [2:0][FLEN-1:0]      fpu_operands_o,
  output roundmode_e                fpu_rnd_mode_o,
  output operation_e                fpu_op_o,
  output logic                      fpu_op_mod_o,
  output fp_format_e                fpu_src_fmt_o,
  output fp_format_e                fpu_dst_fmt_o,
  output int_format_e               fpu_int_fmt_o,
  output logic                      fpu_vectorial_op_o,
  output logic [TAG_WIDTH-1:0]      fpu_tag_o,
  output logic                      fpu_in_valid_o,
  input  logic                      fpu_in_ready_i,
  output logic                      fpu_flush_o,
  input  logic [FLEN-1:0]           fpu_result_i,
  input  status_t                   fpu_status_i,
  input  logic [TAG_WIDTH-1:0]      fpu_tag_i,
  input  logic                      fpu_out_valid_i,
  output logic                      fpu_out_ready_o,
  input  logic                      fpu_busy_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [FLEN-1:0]           rsp_result_o,
  output status_t                   rsp_status_o,
  output logic [ID_WIDTH-1:0]       rsp_id_o,
  input  logic                      flush_i,
  output logic                      idle_o,
  output logic [TAG_WIDTH:0]        inflight_o,
  output logic                      err_o
);

  state_e               r_state;
  logic                 r_err;
  logic                 w_run;
  logic                 w_issue_ok;
  logic                 w_issue;
  logic                 w_result_in;
  logic                 w_wr_ok;
  logic                 w_retire;
  logic                 w_alloc_busy;
  logic [TAG_WIDTH-1:0] w_alloc_ptr;
  rob_entry_t           w_head;

  // The flush cycle itself neither issues nor retires, since the ROB is cleared at its end.
  assign w_run      = (r_state == RUN) & ~flush_i;
  assign w_issue_ok = rst_ni & w_run & ~w_alloc_busy;

  assign fpu_in_valid_o     = cmd_valid_i & w_issue_ok;
  assign cmd_ready_o        = fpu_in_ready_i & w_issue_ok;
  assign w_issue            = fpu_in_valid_o & fpu_in_ready_i;
  assign fpu_operands_o     = cmd_operands_i;
  assign fpu_rnd_mode_o     = cmd_rnd_mode_i;
  assign fpu_op_o           = cmd_op_i;
  assign fpu_op_mod_o       = cmd_op_mod_i;
  assign fpu_src_fmt_o      = cmd_fmt_i;
  assign fpu_dst_fmt_o      = cmd_fmt_i;
  assign fpu_int_fmt_o      = INT_FMT_DEFAULT;
  assign fpu_vectorial_op_o = cmd_vec_i;
  assign fpu_tag_o          = w_alloc_ptr;
  assign fpu_flush_o        = flush_i;
  assign fpu_out_ready_o    = 1'b1;

  assign w_result_in = fpu_out_valid_i & w_run;

  assign rsp_valid_o  = w_head.alloc & w_head.done & w_run;
  assign rsp_result_o = w_head.result;
  assign rsp_status_o = w_head.status;
  assign rsp_id_o     = w_head.id;
  assign w_retire     = rsp_valid_o & rsp_ready_i;

  assign idle_o = (r_state == RUN) & (inflight_o == '0);
  assign err_o  = r_err;

  fpnew_issue_rob #(
    .TAG_WIDTH (TAG_WIDTH)
  ) u_rob (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .i_clear      (flush_i),
    .i_alloc      (w_issue),
    .i_alloc_id   (cmd_id_i),
    .o_alloc_busy (w_alloc_busy),
    .o_alloc_ptr  (w_alloc_ptr),
    .i_wr         (w_result_in),
    .i_wr_tag     (fpu_tag_i),
    .i_wr_result  (fpu_result_i),
    .i_wr_status  (fpu_status_i),
    .o_wr_ok      (w_wr_ok),
    .i_retire     (w_retire),
    .o_head       (w_head),
    .o_count      (inflight_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= RUN;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (flush_i) begin
            r_state <= FLUSH;
            r_err   <= 1'b0;
          end else if (w_result_in && !w_wr_ok) begin
            r_err <= 1'b1;
          end
        end
        FLUSH: begin
          if (!flush_i && !fpu_busy_i) begin
            r_state <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpnew_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fpnew_issue_ctrl
// Purpose : Directed scoreboard bench for fpnew_issue_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fpnew_issue_ctrl;
  import fpnew_issue_pkg::*;

  localparam int TW = 2;

  typedef struct {
    logic [7:0]  id;
    logic [63:0] res;
    logic [4:0]  st;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready_o;
  logic [2:0][63:0] cmd_operands;
  operation_e       cmd_op;
  logic             cmd_op_mod;
  fp_format_e       cmd_fmt;
  roundmode_e       cmd_rnd;
  logic             cmd_vec;
  logic [7:0]       cmd_id;
  logic [2:0][63:0] fpu_operands_o;
  roundmode_e       fpu_rnd_mode_o;
  operation_e       fpu_op_o;
  logic             fpu_op_mod_o;
  fp_format_e       fpu_src_fmt_o;
  fp_format_e       fpu_dst_fmt_o;
  int_format_e      fpu_int_fmt_o;
  logic             fpu_vec_o;
  logic [TW-1:0]    fpu_tag_o;
  logic             fpu_in_valid_o;
  logic             fpu_in_ready;
  logic             fpu_flush_o;
  logic [63:0]      fpu_result;
  status_t          fpu_status;
  logic [TW-1:0]    fpu_tag_in;
  logic             fpu_out_valid;
  logic             fpu_out_ready_o;
  logic             fpu_busy;
  logic             rsp_valid_o;
  logic             rsp_ready;
  logic [63:0]      rsp_result_o;
  status_t          rsp_status_o;
  logic [7:0]       rsp_id_o;
  logic             flush;
  logic             idle_o;
  logic [TW:0]      inflight_o;
  logic             err_o;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  fpnew_issue_ctrl #(.FLEN(64), .TAG_WIDTH(TW), .ID_WIDTH(8)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .cmd_valid_i        (cmd_valid),
    .cmd_ready_o        (cmd_ready_o),
    .cmd_operands_i     (cmd_operands),
    .cmd_op_i           (cmd_op),
    .cmd_op_mod_i       (cmd_op_mod),
    .cmd_fmt_i          (cmd_fmt),
    .cmd_rnd_mode_i     (cmd_rnd),
    .cmd_vec_i          (cmd_vec),
    .cmd_id_i           (cmd_id),
    .fpu_operands_o     (fpu_operands_o),
    .fpu_rnd_mode_o     (fpu_rnd_mode_o),
    .fpu_op_o           (fpu_op_o),
    .fpu_op_mod_o       (fpu_op_mod_o),
    .fpu_src_fmt_o      (fpu_src_fmt_o),
    .fpu_dst_fmt_o      (fpu_dst_fmt_o),
    .fpu_int_fmt_o      (fpu_int_fmt_o),
    .fpu_vectorial_op_o (fpu_vec_o),
    .fpu_tag_o          (fpu_tag_o),
    .fpu_in_valid_o     (fpu_in_valid_o),
    .fpu_in_ready_i     (fpu_in_ready),
    .fpu_flush_o        (fpu_flush_o),
    .fpu_result_i       (fpu_result),
    .fpu_status_i       (fpu_status),
    .fpu_tag_i          (fpu_tag_in),
    .fpu_out_valid_i    (fpu_out_valid),
    .fpu_out_ready_o    (fpu_out_ready_o),
    .fpu_busy_i         (fpu_busy),
    .rsp_valid_o        (rsp_valid_o),
    .rsp_ready_i        (rsp_ready),
    .rsp_result_o       (rsp_result_o),
    .rsp_status_o       (rsp_status_o),
    .rsp_id_o           (rsp_id_o),
    .flush_i            (flush),
    .idle_o             (idle_o),
    .inflight_o         (inflight_o),
    .err_o              (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted response is matched against the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && rsp_valid_o && rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", {63'd0, rsp_valid_o}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_id", {56'd0, rsp_id_o}, {56'd0, e.id});
        check("rsp_result", rsp_result_o, e.res);
        check("rsp_status", {59'd0, rsp_status_o}, {59'd0, e.st});
      end
    end
  end

  task automatic issue(input logic [7:0] id, input logic [63:0] a, input logic [63:0] b,
                       input logic push, input logic [63:0] res, input logic [4:0] st,
                       output logic [TW-1:0] tag);
    bit ok = 1'b0;
    cmd_valid       = 1'b1;
    cmd_id          = id;
    cmd_operands[0] = a;
    cmd_operands[1] = b;
    cmd_operands[2] = 64'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tag = fpu_tag_o;
    if (!ok) check("issue_timeout", 64'd0, 64'd1);
    else if (push) sb.push_back('{id, res, st});
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic fpu_ret(input logic [TW-1:0] tag, input logic [63:0] res, input logic [4:0] st);
    fpu_out_valid = 1'b1;
    fpu_tag_in    = tag;
    fpu_result    = res;
    fpu_status    = st;
    tick();
    fpu_out_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inflight_o == 0) break;
      tick();
    end
    check(name, {61'd0, inflight_o}, 64'd0);
    tick();
  endtask

  initial begin
    logic [TW-1:0] t0, t1, t2, t3, tx;
    rst_n         = 1'b0;
    cmd_valid     = 1'b0;
    cmd_operands  = '0;
    cmd_op        = ADD;
    cmd_op_mod    = 1'b0;
    cmd_fmt       = FP32;
    cmd_rnd       = RNE;
    cmd_vec       = 1'b0;
    cmd_id        = 8'd0;
    fpu_in_ready  = 1'b1;
    fpu_result    = 64'd0;
    fpu_status    = '0;
    fpu_tag_in    = '0;
    fpu_out_valid = 1'b0;
    fpu_busy      = 1'b0;
    rsp_ready     = 1'b1;
    flush         = 1'b0;

    #2;
    check("rst_cmd_ready", {63'd0, cmd_ready_o}, 64'd0);
    check("rst_in_valid", {63'd0, fpu_in_valid_o}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    check("rst_flush", {63'd0, fpu_flush_o}, 64'd0);
    check("rst_idle", {63'd0, idle_o}, 64'd1);
    check("rst_inflight", {61'd0, inflight_o}, 64'd0);
    check("rst_err", {63'd0, err_o}, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single FP32 add, FPU latency 2.
    cmd_valid       = 1'b1;
    cmd_id          = 8'h11;
    cmd_operands[0] = 64'h3F800000;
    cmd_operands[1] = 64'h40000000;
    sb.push_back('{8'h11, 64'h40400000, 5'd0});
    @(negedge clk);
    check("t1_in_valid", {63'd0, fpu_in_valid_o}, 64'd1);
    check("t1_cmd_ready", {63'd0, cmd_ready_o}, 64'd1);
    check("t1_tag", {62'd0, fpu_tag_o}, 64'd0);
    check("t1_src_fmt", {61'd0, fpu_src_fmt_o}, {61'd0, FP32});
    check("t1_dst_fmt", {61'd0, fpu_dst_fmt_o}, {61'd0, FP32});
    check("t1_int_fmt", {62'd0, fpu_int_fmt_o}, {62'd0, INT32});
    check("t1_op", {60'd0, fpu_op_o}, {60'd0, ADD});
    check("t1_opa", fpu_operands_o[0], 64'h3F800000);
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("t1_inflight", {61'd0, inflight_o}, 64'd1);
    check("t1_idle_busy", {63'd0, idle_o}, 64'd0);
    check("t1_rsp_c1", {63'd0, rsp_valid_o}, 64'd0);
    tick();
    fpu_out_valid = 1'b1;
    fpu_tag_in    = '0;
    fpu_result    = 64'h40400000;
    fpu_status    = '0;
    @(negedge clk);
    check("t1_rsp_c2", {63'd0, rsp_valid_o}, 64'd0);
    tick();
    fpu_out_valid = 1'b0;
    @(negedge clk);
    check("t1_rsp_c3", {63'd0, rsp_valid_o}, 64'd1);
    tick();
    @(negedge clk);
    check("t1_inflight_end", {61'd0, inflight_o}, 64'd0);
    check("t1_idle_end", {63'd0, idle_o}, 64'd1);
    tick();

    // Out-of-order returns.
    issue(8'd1, 64'd0, 64'd0, 1'b1, 64'h100, 5'h00, t0);
    issue(8'd2, 64'd0, 64'd0, 1'b1, 64'h200, 5'h01, t1);
    issue(8'd3, 64'd0, 64'd0, 1'b1, 64'h300, 5'h10, t2);
    fpu_ret(t2, 64'h300, 5'h10);
    @(negedge clk);
    check("t2_head_wait", {63'd0, rsp_valid_o}, 64'd0);
    tick();
    fpu_ret(t0, 64'h100, 5'h00);
    fpu_ret(t1, 64'h200, 5'h01);
    wait_drain("t2_drain");

    // Full ROB with response backpressure.
    rsp_ready = 1'b0;
    issue(8'h21, 64'd0, 64'd0, 1'b1, 64'hA1, 5'h00, t0);
    issue(8'h22, 64'd0, 64'd0, 1'b1, 64'hA2, 5'h02, t1);
    issue(8'h23, 64'd0, 64'd0, 1'b1, 64'hA3, 5'h04, t2);
    issue(8'h24, 64'd0, 64'd0, 1'b1, 64'hA4, 5'h08, t3);
    fpu_ret(t0, 64'hA1, 5'h00);
    fpu_ret(t1, 64'hA2, 5'h02);
    fpu_ret(t2, 64'hA3, 5'h04);
    fpu_ret(t3, 64'hA4, 5'h08);
    @(negedge clk);
    check("t3_full_ready", {63'd0, cmd_ready_o}, 64'd0);
    check("t3_full_inflight", {61'd0, inflight_o}, 64'd4);
    check("t3_full_rsp", {63'd0, rsp_valid_o}, 64'd1);
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t3_bubble", {63'd0, cmd_ready_o}, 64'd0);
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    check("t3_ready_after", {63'd0, cmd_ready_o}, 64'd1);
    check("t3_inflight_after", {61'd0, inflight_o}, 64'd3);
    tick();
    rsp_ready = 1'b1;
    wait_drain("t3_drain");

    // Flush with three in flight while the FPU stays busy.
    issue(8'h31, 64'd0, 64'd0, 1'b0, 64'd0, 5'd0, t0);
    issue(8'h32, 64'd0, 64'd0, 1'b0, 64'd0, 5'd0, t1);
    issue(8'h33, 64'd0, 64'd0, 1'b0, 64'd0, 5'd0, t2);
    fpu_busy = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    check("t4_flush_pulse", {63'd0, fpu_flush_o}, 64'd1);
    check("t4_ready_flush", {63'd0, cmd_ready_o}, 64'd0);
    tick();
    flush         = 1'b0;
    fpu_out_valid = 1'b1;
    fpu_tag_in    = t0;
    fpu_result    = 64'hBAD;
    @(negedge clk);
    check("t4_flush_low", {63'd0, fpu_flush_o}, 64'd0);
    check("t4_ready_busy1", {63'd0, cmd_ready_o}, 64'd0);
    check("t4_inflight_clr", {61'd0, inflight_o}, 64'd0);
    check("t4_idle_in_flush", {63'd0, idle_o}, 64'd0);
    tick();
    fpu_out_valid = 1'b0;
    @(negedge clk);
    check("t4_ready_busy2", {63'd0, cmd_ready_o}, 64'd0);
    check("t4_no_rsp", {63'd0, rsp_valid_o}, 64'd0);
    tick();
    fpu_busy = 1'b0;
    @(negedge clk);
    check("t4_ready_exit", {63'd0, cmd_ready_o}, 64'd0);
    tick();
    @(negedge clk);
    check("t4_ready_run", {63'd0, cmd_ready_o}, 64'd1);
    check("t4_idle", {63'd0, idle_o}, 64'd1);
    check("t4_err", {63'd0, err_o}, 64'd0);
    tick();

    // Stray tag while only tag 0 is in flight.
    issue(8'h55, 64'd0, 64'd0, 1'b1, 64'h555, 5'h00, tx);
    check("t5_tag0", {62'd0, tx}, 64'd0);
    fpu_ret(2'd3, 64'hDEAD, 5'h1F);
    @(negedge clk);
    check("t5_err", {63'd0, err_o}, 64'd1);
    check("t5_no_rsp", {63'd0, rsp_valid_o}, 64'd0);
    tick();
    tick();
    @(negedge clk);
    check("t5_err_sticky", {63'd0, err_o}, 64'd1);
    tick();
    fpu_ret(2'd0, 64'h555, 5'h00);
    wait_drain("t5_drain");
    check("t5_err_end", {63'd0, err_o}, 64'd1);

    // Asynchronous reset in the middle of a burst.
    rsp_ready = 1'b0;
    issue(8'h61, 64'd0, 64'd0, 1'b0, 64'd0, 5'd0, tx);
    issue(8'h62, 64'd0, 64'd0, 1'b0, 64'd0, 5'd0, tx);
    cmd_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_cmd_ready", {63'd0, cmd_ready_o}, 64'd0);
    check("t6_in_valid", {63'd0, fpu_in_valid_o}, 64'd0);
    check("t6_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    check("t6_idle", {63'd0, idle_o}, 64'd1);
    check("t6_inflight", {61'd0, inflight_o}, 64'd0);
    check("t6_err", {63'd0, err_o}, 64'd0);
    cmd_valid = 1'b0;
    tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    tick();
    issue(8'h66, 64'd0, 64'd0, 1'b1, 64'h666, 5'h04, tx);
    check("t6_tag0", {62'd0, tx}, 64'd0);
    fpu_ret(tx, 64'h666, 5'h04);
    wait_drain("t6_drain");

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
